adsr_envelope: RTL and testbench

//  Per-voice ADSR envelope generator. Produces the 16-bit signed amplitude word

---
 rtl/adsr_pkg.sv | 15 +
 rtl/adsr_sat_step.sv | 40 ++++
 rtl/adsr_envelope.sv | 128 ++++++++++++
 tb/tb_adsr_envelope.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adsr_pkg.sv
// Shared types and constants for the ADSR envelope generator.
package adsr_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } env_state_t;

  localparam int ENV_ACC_W = 23;
  localparam logic [ENV_ACC_W-1:0] ENV_MAX = {ENV_ACC_W{1'b1}};

endpackage

// File: rtl/adsr_sat_step.sv
// Combinational saturating add/sub of the envelope accumulator against a clamp bound.
// hit flags that the result reached or crossed the bound and was clamped to it.
module adsr_sat_step #(
  parameter int W = 23
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  input  logic [W-1:0] bound,
  output logic [W-1:0] y,
  output logic         hit
);

  logic [W:0] sum;
  logic [W:0] diff;

  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    y    = a;
    hit  = 1'b0;
    if (sub) begin
      // diff[W] is the borrow: a result below zero is always at or under the bound
      if (diff[W] || (diff[W-1:0] <= bound)) begin
        y   = bound;
        hit = 1'b1;
      end else begin
        y = diff[W-1:0];
      end
    end else begin
      if (sum >= {1'b0, bound}) begin
        y   = bound;
        hit = 1'b1;
      end else begin
        y = sum[W-1:0];
      end
    end
  end

endmodule

// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope; advances only on sample_tick.
// Build macro ADSR_EXP_RELEASE_EN selects an exponential release tail instead of a linear ramp.
module adsr_envelope
  import adsr_pkg::*;
#(
  parameter int ACC_W = ENV_ACC_W
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        sample_tick,
  input  logic        key_on,
  input  logic [15:0] attack_rate,
  input  logic [15:0] decay_rate,
  input  logic [14:0] sustain_level,
  input  logic [15:0] release_rate,
  output logic [15:0] amp,
  output logic [2:0]  env_state,
  output logic        busy
);

  localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

  env_state_t       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             key_prev_q, key_prev_d;
  logic             busy_q, busy_d;

  logic [ACC_W-1:0] target;
  logic [ACC_W-1:0] rel_step;
  logic [ACC_W-1:0] step_b;
  logic             step_sub;
  logic [ACC_W-1:0] step_bound;
  logic [ACC_W-1:0] step_y;
  logic             step_hit;

  assign target = {sustain_level, {(ACC_W-15){1'b0}}};

`ifdef ADSR_EXP_RELEASE_EN
  logic [ACC_W-1:0] rel_shift;
  assign rel_shift = acc_q >> release_rate[3:0];
  // +1 keeps the tail moving once the shifted value reaches zero
  assign rel_step  = (rel_shift == ACC_MAX) ? ACC_MAX : rel_shift + ACC_W'(1);
`else
  assign rel_step  = ACC_W'(release_rate);
`endif

  always_comb begin
    step_b     = rel_step;
    step_sub   = 1'b1;
    step_bound = '0;
    case (state_q)
      ATTACK: begin
        step_b     = ACC_W'(attack_rate);
        step_sub   = 1'b0;
        step_bound = ACC_MAX;
      end
      DECAY: begin
        step_b     = ACC_W'(decay_rate);
        step_bound = target;
      end
      default: ;
    endcase
  end

  adsr_sat_step #(.W(ACC_W)) u_step (
    .a     (acc_q),
    .b     (step_b),
    .sub   (step_sub),
    .bound (step_bound),
    .y     (step_y),
    .hit   (step_hit)
  );

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    key_prev_d = key_prev_q;
    if (sample_tick) begin
      key_prev_d = key_on;
      if (key_on && !key_prev_q) begin
        state_d = ATTACK;
      end else if (!key_on && (state_q != IDLE) && (state_q != RELEASE)) begin
        state_d = RELEASE;
      end else begin
        case (state_q)
          IDLE: acc_d = '0;
          ATTACK: begin
            acc_d = step_y;
            if (step_hit) state_d = DECAY;
          end
          DECAY: begin
            acc_d = step_y;
            if (step_hit) state_d = SUSTAIN;
          end
          SUSTAIN: acc_d = target;
          RELEASE: begin
            acc_d = step_y;
            if (step_hit) state_d = IDLE;
          end
          default: begin
            state_d = IDLE;
            acc_d   = '0;
          end
        endcase
      end
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      key_prev_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      key_prev_q <= key_prev_d;
      busy_q     <= busy_d;
    end
  end

  assign amp       = {1'b0, acc_q[ACC_W-1 -: 15]};
  assign env_state = state_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_adsr_envelope.sv
// Self-checking bench for adsr_envelope: vector table, directed corner cases, randomized run vs model.
module tb_adsr_envelope;

`ifdef ADSR_EXP_RELEASE_EN
  localparam bit EXP = 1'b1;
`else
  localparam bit EXP = 1'b0;
`endif

  localparam int S_IDLE = 0, S_ATK = 1, S_DEC = 2, S_SUS = 3, S_REL = 4;
  localparam longint ACC_TOP = (longint'(1) << 23) - 1;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        sample_tick = 1'b0;
  logic        key_on = 1'b0;
  logic [15:0] attack_rate = '0;
  logic [15:0] decay_rate = '0;
  logic [14:0] sustain_level = '0;
  logic [15:0] release_rate = '0;
  logic [15:0] amp;
  logic [2:0]  env_state;
  logic        busy;

  int checks = 0;
  int errors = 0;

  longint m_acc;
  int     m_st;
  bit     m_kp;

  adsr_envelope dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .sample_tick   (sample_tick),
    .key_on        (key_on),
    .attack_rate   (attack_rate),
    .decay_rate    (decay_rate),
    .sustain_level (sustain_level),
    .release_rate  (release_rate),
    .amp           (amp),
    .env_state     (env_state),
    .busy          (busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    bit          key;
    logic [15:0] ar;
    logic [15:0] rr;
    logic [2:0]  st;
    logic [15:0] amp;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic void model_reset();
    m_acc = 0;
    m_st  = S_IDLE;
    m_kp  = 1'b0;
  endfunction

  // Envelope rules applied to an unbounded integer level, clamped by min/max.
  function automatic void model_tick();
    longint tgt, nxt, stp;
    tgt = longint'(sustain_level) * 256;
    if (key_on && !m_kp) m_st = S_ATK;
    else if (!key_on && m_st != S_IDLE && m_st != S_REL) m_st = S_REL;
    else begin
      case (m_st)
        S_IDLE: m_acc = 0;
        S_ATK: begin
          nxt = m_acc + longint'(attack_rate);
          if (nxt >= ACC_TOP) begin m_acc = ACC_TOP; m_st = S_DEC; end
          else m_acc = nxt;
        end
        S_DEC: begin
          nxt = m_acc - longint'(decay_rate);
          if (nxt <= tgt) begin m_acc = tgt; m_st = S_SUS; end
          else m_acc = nxt;
        end
        S_SUS: m_acc = tgt;
        default: begin
          if (EXP) stp = (m_acc / (longint'(1) << release_rate[3:0])) + 1;
          else stp = longint'(release_rate);
          nxt = m_acc - stp;
          if (nxt <= 0) begin m_acc = 0; m_st = S_IDLE; end
          else m_acc = nxt;
        end
      endcase
    end
    m_kp = key_on;
  endfunction

  task automatic chk_model(input string name);
    chk({name, "_amp"}, {16'd0, amp}, 32'(m_acc / 256));
    chk({name, "_state"}, {29'd0, env_state}, 32'(m_st));
    chk({name, "_busy"}, {31'd0, busy}, {31'd0, (m_st != S_IDLE)});
  endtask

  // Called at a negedge; returns at the negedge after the tick edge.
  task automatic do_tick();
    sample_tick = 1'b1;
    @(negedge Clk);
    sample_tick = 1'b0;
    model_tick();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    @(negedge Clk);
  endtask

  initial begin
    int n;
    logic [15:0] last_amp;
    model_reset();
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    chk("reset_amp", {16'd0, amp}, 32'h0);
    chk("reset_state", {29'd0, env_state}, S_IDLE);
    chk("reset_busy", {31'd0, busy}, 32'h0);

    // ---- table-driven vectors (decay_rate/sustain unused: DECAY never reached) ----
    decay_rate = 16'h1000;
    sustain_level = 15'h2000;
    tbl[0]  = '{1'b1, 16'h4000, 16'h0801, 3'd1, 16'h0000};
    tbl[1]  = '{1'b1, 16'h4000, 16'h0801, 3'd1, 16'h0040};
    tbl[2]  = '{1'b1, 16'h4000, 16'h0801, 3'd1, 16'h0080};
    tbl[3]  = '{1'b0, 16'h4000, 16'h0801, 3'd4, 16'h0080};
    tbl[4]  = '{1'b0, 16'h4000, 16'h0801, 3'd4, EXP ? 16'h003F : 16'h0077};
    tbl[5]  = '{1'b1, 16'h4000, 16'h0801, 3'd1, EXP ? 16'h003F : 16'h0077};
    tbl[6]  = '{1'b1, 16'h4000, 16'h0801, 3'd1, EXP ? 16'h007F : 16'h00B7};
    tbl[7]  = '{1'b1, 16'h0000, 16'h0801, 3'd1, EXP ? 16'h007F : 16'h00B7};
    tbl[8]  = '{1'b0, 16'h0000, 16'h0801, 3'd4, EXP ? 16'h007F : 16'h00B7};
    tbl[9]  = '{1'b0, 16'h0000, 16'hFFFF, EXP ? 3'd4 : 3'd0, EXP ? 16'h007F : 16'h0000};
    tbl[10] = '{1'b0, 16'h0000, 16'h0000, 3'd0, 16'h0000};
    for (int i = 0; i < 11; i++) begin
      key_on = tbl[i].key;
      attack_rate = tbl[i].ar;
      release_rate = tbl[i].rr;
      do_tick();
      chk($sformatf("vec%0d_state", i), {29'd0, env_state}, {29'd0, tbl[i].st});
      chk($sformatf("vec%0d_amp", i), {16'd0, amp}, {16'd0, tbl[i].amp});
      chk($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, (tbl[i].st != 3'd0)});
    end

    // ---- full attack, decay to sustain, sustain tracking ----
    do_reset();
    attack_rate = 16'hFFFF;
    decay_rate = 16'h1000;
    sustain_level = 15'h4000;
    key_on = 1'b1;
    do_tick();
    chk("atk_enter_state", {29'd0, env_state}, S_ATK);
    n = 0;
    while (env_state == 3'(S_ATK) && n < 300) begin
      do_tick();
      n++;
    end
    chk("atk_steps", n, 129);
    chk("atk_peak_amp", {16'd0, amp}, 32'h7FFF);
    chk("atk_to_decay", {29'd0, env_state}, S_DEC);
    n = 0;
    while (env_state == 3'(S_DEC) && n < 2000) begin
      do_tick();
      n++;
    end
    chk("dec_steps", n, 1024);
    chk("sus_amp", {16'd0, amp}, 32'h4000);
    chk("sus_state", {29'd0, env_state}, S_SUS);
    sustain_level = 15'h2000;
    do_tick();
    chk("sus_track_amp", {16'd0, amp}, 32'h2000);
    sustain_level = 15'h4000;
    do_tick();
    chk("sus_back_amp", {16'd0, amp}, 32'h4000);

    // ---- release to idle ----
    key_on = 1'b0;
    release_rate = EXP ? 16'h0004 : 16'h0800;
    do_tick();
    chk("rel_enter_state", {29'd0, env_state}, S_REL);
    chk("rel_enter_amp", {16'd0, amp}, 32'h4000);
    n = 0;
    last_amp = amp;
    while (env_state == 3'(S_REL) && n < 5000) begin
      do_tick();
      n++;
      chk_model("rel_walk");
      if (amp > last_amp) chk("rel_monotonic", {16'd0, amp}, {16'd0, last_amp});
      last_amp = amp;
    end
    if (!EXP) chk("rel_steps", n, 2048);
    chk("rel_end_state", {29'd0, env_state}, S_IDLE);
    chk("rel_end_amp", {16'd0, amp}, 32'h0);
    chk("rel_end_busy", {31'd0, busy}, 32'h0);

    // ---- retrigger during release from 0x3000 ----
    do_reset();
    attack_rate = 16'hFFFF;
    decay_rate = 16'hFFFF;
    sustain_level = 15'h3000;
    key_on = 1'b1;
    n = 0;
    while (env_state != 3'(S_SUS) && n < 400) begin
      do_tick();
      n++;
    end
    chk("retrig_sus_state", {29'd0, env_state}, S_SUS);
    key_on = 1'b0;
    do_tick();
    chk("retrig_rel_state", {29'd0, env_state}, S_REL);
    chk("retrig_rel_amp", {16'd0, amp}, 32'h3000);
    key_on = 1'b1;
    attack_rate = 16'h0000;
    do_tick();
    chk("retrig_atk_state", {29'd0, env_state}, S_ATK);
    chk("retrig_atk_amp", {16'd0, amp}, 32'h3000);
    repeat (3) do_tick();
    chk("atk_rate0_state", {29'd0, env_state}, S_ATK);
    chk("atk_rate0_amp", {16'd0, amp}, 32'h3000);

    // ---- short gate glitch and no-tick cycles ----
    key_on = 1'b0;
    @(negedge Clk);
    key_on = 1'b1;
    do_tick();
    chk_model("glitch");
    chk("glitch_state", {29'd0, env_state}, S_ATK);
    attack_rate = 16'h1000;
    repeat (5) @(negedge Clk);
    chk("no_tick_amp", {16'd0, amp}, 32'h3000);
    do_tick();
    chk_model("after_idle_cycles");

    // ---- async reset mid-attack ----
    #2 Reset = 1'b1;
    #1;
    chk("async_rst_amp", {16'd0, amp}, 32'h0);
    chk("async_rst_state", {29'd0, env_state}, S_IDLE);
    chk("async_rst_busy", {31'd0, busy}, 32'h0);
    @(negedge Clk);
    key_on = 1'b0;
    Reset = 1'b0;
    model_reset();
    repeat (3) do_tick();
    chk("post_rst_state", {29'd0, env_state}, S_IDLE);
    chk("post_rst_amp", {16'd0, amp}, 32'h0);
    key_on = 1'b1;
    do_tick();
    chk("post_rst_rise", {29'd0, env_state}, S_ATK);

    // ---- randomized run against the model ----
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 31) == 0) key_on = ~key_on;
      if ($urandom_range(0, 31) == 0)
        attack_rate = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom_range(1, 16'hFFFF));
      if ($urandom_range(0, 31) == 0)
        decay_rate = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom_range(1, 16'hFFFF));
      if ($urandom_range(0, 31) == 0)
        release_rate = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom_range(1, 16'hFFFF));
      if ($urandom_range(0, 31) == 0) sustain_level = 15'($urandom);
      if ($urandom_range(0, 39) == 0) begin
        key_on = ~key_on;
        @(negedge Clk);
        key_on = ~key_on;
      end
      repeat ($urandom_range(0, 2)) @(negedge Clk);
      if ($urandom_range(0, 499) == 0) do_reset();
      do_tick();
      chk_model("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    errors++;
    $display("FAIL timeout at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
